// File: rtl/nabp_angle_sequencer_if.sv
// Host, filtered-RAM loader and swap-control signals of the angle sequencer.
// The status outputs exist only when NABP_ANGLE_SEQ_STATUS_EN is defined.
interface nabp_angle_sequencer_if #(
    parameter int unsigned ANGLE_WIDTH = 9
);
    logic                   start_i;
    logic                   abort_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   fl_start_o;
    logic [ANGLE_WIDTH-1:0] fl_angle_o;
    logic                   fl_done_i;
    logic                   hs_next_angle_i;
    logic                   hs_next_angle_ack_o;
    logic [ANGLE_WIDTH-1:0] hs_angle_o;
`ifdef NABP_ANGLE_SEQ_STATUS_EN
    logic [15:0]            stall_cycles_o;
    logic [ANGLE_WIDTH-1:0] angles_done_o;
`endif

    modport master (
`ifdef NABP_ANGLE_SEQ_STATUS_EN
        output stall_cycles_o,
        output angles_done_o,
`endif
        input  start_i,
        input  abort_i,
        output busy_o,
        output done_o,
        output fl_start_o,
        output fl_angle_o,
        input  fl_done_i,
        input  hs_next_angle_i,
        output hs_next_angle_ack_o,
        output hs_angle_o
    );

    modport slave (
`ifdef NABP_ANGLE_SEQ_STATUS_EN
        input  stall_cycles_o,
        input  angles_done_o,
`endif
        output start_i,
        output abort_i,
        input  busy_o,
        input  done_o,
        input  fl_start_o,
        input  fl_angle_o,
        output fl_done_i,
        output hs_next_angle_i,
        input  hs_next_angle_ack_o,
        input  hs_angle_o
    );
endinterface

// File: rtl/nabp_angle_sequencer.sv
// Walks projection angles for one backprojection frame, prefetching each angle through the loader.
// Optional stall/progress counters are enabled with NABP_ANGLE_SEQ_STATUS_EN.
module nabp_angle_sequencer #(
    parameter int unsigned ANGLE_WIDTH = 9,
    parameter int unsigned ANGLE_START = 0,
    parameter int unsigned ANGLE_END   = 180,
    parameter int unsigned ANGLE_STEP  = 1
) (
    input logic                    clk_i,
    input logic                    reset_n_i,
    nabp_angle_sequencer_if.master seq_if
);

    localparam logic [ANGLE_WIDTH-1:0] StartAngle = (ANGLE_WIDTH)'(ANGLE_START);
    localparam logic [ANGLE_WIDTH:0]   StepWide   = (ANGLE_WIDTH+1)'(ANGLE_STEP);
    localparam logic [ANGLE_WIDTH:0]   EndWide    = (ANGLE_WIDTH+1)'(ANGLE_END);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLoadWait,
        StOffer,
        StAck,
        StFlush
    } state_e;

    state_e                 state_q, state_d;
    logic [ANGLE_WIDTH-1:0] load_angle_q, load_angle_d;
    logic [ANGLE_WIDTH-1:0] fl_angle_q, fl_angle_d;
    logic [ANGLE_WIDTH-1:0] hs_angle_q, hs_angle_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   fl_start_q, fl_start_d;
    logic                   ack_q, ack_d;
    logic [ANGLE_WIDTH:0]   next_angle;
    logic                   start_accept;

    // One extra bit so an end angle of 2^ANGLE_WIDTH cannot wrap the compare.
    assign next_angle   = {1'b0, load_angle_q} + StepWide;
    assign start_accept = (state_q == StIdle) && seq_if.start_i && !seq_if.abort_i;

    always_comb begin
        state_d      = state_q;
        load_angle_d = load_angle_q;
        last_d       = last_q;
        done_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (seq_if.start_i) begin
                    load_angle_d = StartAngle;
                    last_d       = 1'b0;
                    state_d      = StLoad;
                end
            end
            StLoad:     state_d = StLoadWait;
            StLoadWait: if (seq_if.fl_done_i) state_d = StOffer;
            StOffer:    if (seq_if.hs_next_angle_i) state_d = StAck;
            StAck: begin
                if (next_angle >= EndWide) begin
                    last_d  = 1'b1;
                    state_d = StFlush;
                end else begin
                    load_angle_d = next_angle[ANGLE_WIDTH-1:0];
                    state_d      = StLoad;
                end
            end
            StFlush: begin
                if (seq_if.hs_next_angle_i && last_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over everything, including a start in the same cycle.
        if (seq_if.abort_i) begin
            state_d      = StIdle;
            load_angle_d = load_angle_q;
            last_d       = last_q;
            done_d       = 1'b0;
        end

        fl_start_d = (state_d == StLoad);
        ack_d      = (state_d == StAck);
        busy_d     = (state_d != StIdle);
        fl_angle_d = fl_start_d ? load_angle_d : fl_angle_q;
        hs_angle_d = ack_d ? load_angle_q : hs_angle_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= StIdle;
            load_angle_q <= StartAngle;
            fl_angle_q   <= StartAngle;
            hs_angle_q   <= StartAngle;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fl_start_q   <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_angle_q <= load_angle_d;
            fl_angle_q   <= fl_angle_d;
            hs_angle_q   <= hs_angle_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fl_start_q   <= fl_start_d;
            ack_q        <= ack_d;
        end
    end

    assign seq_if.busy_o              = busy_q;
    assign seq_if.done_o              = done_q;
    assign seq_if.fl_start_o          = fl_start_q;
    assign seq_if.fl_angle_o          = fl_angle_q;
    assign seq_if.hs_next_angle_ack_o = ack_q;
    assign seq_if.hs_angle_o          = hs_angle_q;

`ifdef NABP_ANGLE_SEQ_STATUS_EN
    logic [15:0]            stall_cycles_q, stall_cycles_d;
    logic [ANGLE_WIDTH-1:0] angles_done_q, angles_done_d;

    // Stalls are cycles where swap control is already asking but the loader is not done.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        angles_done_d  = angles_done_q;
        if (start_accept) begin
            stall_cycles_d = '0;
            angles_done_d  = '0;
        end else begin
            if ((state_q == StLoadWait) && seq_if.hs_next_angle_i && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_d = stall_cycles_q + 16'd1;
            end
            if (ack_d) begin
                angles_done_d = angles_done_q + (ANGLE_WIDTH)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_cycles_q <= '0;
            angles_done_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            angles_done_q  <= angles_done_d;
        end
    end

    assign seq_if.stall_cycles_o = stall_cycles_q;
    assign seq_if.angles_done_o  = angles_done_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_nabp_angle_sequencer.sv
// Directed bench for nabp_angle_sequencer: default frame, stepped frame, stalls, consumer pacing,
// abort, reset and start conflicts. Status checks compile in with NABP_ANGLE_SEQ_STATUS_EN.
module tb_nabp_angle_sequencer;

    logic clk;
    logic rstN;

    nabp_angle_sequencer_if #(.ANGLE_WIDTH(9)) ifA ();
    nabp_angle_sequencer_if #(.ANGLE_WIDTH(9)) ifB ();

    nabp_angle_sequencer #(
        .ANGLE_WIDTH(9), .ANGLE_START(0), .ANGLE_END(180), .ANGLE_STEP(1)
    ) dut (
        .clk_i(clk), .reset_n_i(rstN), .seq_if(ifA.master)
    );

    nabp_angle_sequencer #(
        .ANGLE_WIDTH(9), .ANGLE_START(0), .ANGLE_END(180), .ANGLE_STEP(45)
    ) dutStep (
        .clk_i(clk), .reset_n_i(rstN), .seq_if(ifB.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int flLatency = 2;
    int flCntA = -1;
    int flCntB = -1;
    logic [8:0] ackQ[$];
    logic [8:0] flQ[$];
    logic [8:0] ackQB[$];
    logic [8:0] flQB[$];
    int ackCyc[$];
    int flCyc[$];
    int doneCnt = 0;
    int doneCyc = 0;
    int doneCntB = 0;
    logic busyAtDone = 1'b1;

    // Advance one clock, sample just after the edge, play the loaders and log DUT events.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        ifA.fl_done_i = 1'b0;
        if (flCntA > 0) begin
            flCntA--;
            if (flCntA == 0) begin
                ifA.fl_done_i = 1'b1;
                flCntA = -1;
            end
        end
        if (ifA.fl_start_o) begin
            flQ.push_back(ifA.fl_angle_o);
            flCyc.push_back(cyc);
            flCntA = flLatency - 1;
        end
        if (ifA.hs_next_angle_ack_o) begin
            ackQ.push_back(ifA.hs_angle_o);
            ackCyc.push_back(cyc);
        end
        if (ifA.done_o) begin
            doneCnt++;
            doneCyc = cyc;
            busyAtDone = ifA.busy_o;
        end
        ifB.fl_done_i = 1'b0;
        if (flCntB > 0) begin
            flCntB--;
            if (flCntB == 0) begin
                ifB.fl_done_i = 1'b1;
                flCntB = -1;
            end
        end
        if (ifB.fl_start_o) begin
            flQB.push_back(ifB.fl_angle_o);
            flCntB = 1;
        end
        if (ifB.hs_next_angle_ack_o) ackQB.push_back(ifB.hs_angle_o);
        if (ifB.done_o) doneCntB++;
    endtask

    task automatic clearLogs();
        ackQ.delete();
        flQ.delete();
        ackCyc.delete();
        flCyc.delete();
        doneCnt = 0;
        busyAtDone = 1'b1;
    endtask

    task automatic abortToIdle();
        ifA.abort_i = 1'b1;
        tick();
        ifA.abort_i = 1'b0;
        tick();
    endtask

    task automatic pulseStart();
        ifA.start_i = 1'b1;
        tick();
        ifA.start_i = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (ifA.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0b want 0", ifA.busy_o); end
        vectors++; if (ifA.done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %0b want 0", ifA.done_o); end
        vectors++; if (ifA.fl_start_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fl_start: got %0b want 0", ifA.fl_start_o); end
        vectors++; if (ifA.hs_next_angle_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack: got %0b want 0", ifA.hs_next_angle_ack_o); end
        vectors++; if (ifA.hs_angle_o !== 9'd0) begin miscompares++; $display("[TB] FAIL reset_hs_angle: got %0d want 0", ifA.hs_angle_o); end
        vectors++; if (ifA.fl_angle_o !== 9'd0) begin miscompares++; $display("[TB] FAIL reset_fl_angle: got %0d want 0", ifA.fl_angle_o); end
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_full_frame();
        int n;
        int last;
        clearLogs();
        flLatency = 3;
        ifA.hs_next_angle_i = 1'b1;
        pulseStart();
        n = 0;
        while (doneCnt == 0 && n < 3000) begin tick(); n++; end
        repeat (5) tick();
        vectors++; if (doneCnt !== 1) begin miscompares++; $display("[TB] FAIL frame_done_count: got %0d want 1", doneCnt); end
        vectors++; if (ackQ.size() != 180) begin miscompares++; $display("[TB] FAIL frame_ack_count: got %0d want 180", ackQ.size()); end
        vectors++; if (flQ.size() != 180) begin miscompares++; $display("[TB] FAIL frame_fl_count: got %0d want 180", flQ.size()); end
        for (int i = 0; i < ackQ.size() && i < flQ.size(); i++) begin
            vectors++; if (ackQ[i] !== 9'(i)) begin miscompares++; $display("[TB] FAIL frame_ack_angle[%0d]: got %0d want %0d", i, ackQ[i], i); end
            vectors++; if (flQ[i] !== 9'(i)) begin miscompares++; $display("[TB] FAIL frame_fl_angle[%0d]: got %0d want %0d", i, flQ[i], i); end
            vectors++; if (!(flCyc[i] < ackCyc[i])) begin miscompares++; $display("[TB] FAIL frame_fl_before_ack[%0d]: fl cycle %0d ack cycle %0d", i, flCyc[i], ackCyc[i]); end
        end
        if (ackCyc.size() > 0) begin
            last = ackCyc[ackCyc.size()-1];
            vectors++; if (doneCyc != last + 2) begin miscompares++; $display("[TB] FAIL frame_done_timing: got cycle %0d want %0d", doneCyc, last + 2); end
        end
        vectors++; if (busyAtDone !== 1'b0) begin miscompares++; $display("[TB] FAIL frame_busy_at_done: got %0b want 0", busyAtDone); end
`ifdef NABP_ANGLE_SEQ_STATUS_EN
        vectors++; if (ifA.angles_done_o !== 9'd180) begin miscompares++; $display("[TB] FAIL frame_angles_done: got %0d want 180", ifA.angles_done_o); end
        vectors++; if (ifA.stall_cycles_o !== 16'd360) begin miscompares++; $display("[TB] FAIL frame_stall_cycles: got %0d want 360", ifA.stall_cycles_o); end
`endif
    endtask

    task automatic test_stepped();
        int n;
        logic [8:0] expStep [4];
        expStep = '{9'd0, 9'd45, 9'd90, 9'd135};
        flQB.delete();
        ackQB.delete();
        doneCntB = 0;
        ifB.start_i = 1'b1;
        tick();
        ifB.start_i = 1'b0;
        n = 0;
        while (doneCntB == 0 && n < 300) begin tick(); n++; end
        repeat (3) tick();
        vectors++; if (ackQB.size() != 4) begin miscompares++; $display("[TB] FAIL step_ack_count: got %0d want 4", ackQB.size()); end
        vectors++; if (flQB.size() != 4) begin miscompares++; $display("[TB] FAIL step_fl_count: got %0d want 4", flQB.size()); end
        vectors++; if (doneCntB != 1) begin miscompares++; $display("[TB] FAIL step_done_count: got %0d want 1", doneCntB); end
        for (int i = 0; i < 4 && i < flQB.size() && i < ackQB.size(); i++) begin
            vectors++; if (flQB[i] !== expStep[i]) begin miscompares++; $display("[TB] FAIL step_fl_angle[%0d]: got %0d want %0d", i, flQB[i], expStep[i]); end
            vectors++; if (ackQB[i] !== expStep[i]) begin miscompares++; $display("[TB] FAIL step_ack_angle[%0d]: got %0d want %0d", i, ackQB[i], expStep[i]); end
        end
    endtask

    task automatic test_stall();
        int n;
        clearLogs();
        flLatency = 20;
        ifA.hs_next_angle_i = 1'b1;
        pulseStart();
        n = 0;
        while (ackQ.size() < 1 && n < 200) begin tick(); n++; end
        vectors++; if (ackQ.size() != 1 || flCyc.size() < 1) begin
            miscompares++; $display("[TB] FAIL stall_first_ack: got %0d acks want 1", ackQ.size());
        end else if (ackCyc[0] - flCyc[0] != 21) begin
            miscompares++; $display("[TB] FAIL stall_first_ack_latency: got %0d want 21", ackCyc[0] - flCyc[0]);
        end
`ifdef NABP_ANGLE_SEQ_STATUS_EN
        vectors++; if (ifA.stall_cycles_o !== 16'd19) begin miscompares++; $display("[TB] FAIL stall_cycles_first: got %0d want 19", ifA.stall_cycles_o); end
        vectors++; if (ifA.angles_done_o !== 9'd1) begin miscompares++; $display("[TB] FAIL stall_angles_done: got %0d want 1", ifA.angles_done_o); end
`endif
        n = 0;
        while (ackQ.size() < 2 && n < 200) begin tick(); n++; end
        vectors++; if (ackQ.size() != 2) begin
            miscompares++; $display("[TB] FAIL stall_second_ack: got %0d acks want 2", ackQ.size());
        end else if (ackCyc[1] - ackCyc[0] != 22) begin
            miscompares++; $display("[TB] FAIL stall_ack_spacing: got %0d want 22", ackCyc[1] - ackCyc[0]);
        end
        abortToIdle();
    endtask

    task automatic test_back_to_back();
        int n;
        clearLogs();
        flLatency = 2;
        ifA.hs_next_angle_i = 1'b1;
        pulseStart();
        n = 0;
        while (ackQ.size() < 4 && n < 100) begin tick(); n++; end
        vectors++; if (ackQ.size() < 4) begin miscompares++; $display("[TB] FAIL b2b_ack_count: got %0d want 4", ackQ.size()); end
        for (int i = 1; i < 4 && i < ackQ.size(); i++) begin
            vectors++; if (ackCyc[i] - ackCyc[i-1] != 4) begin miscompares++; $display("[TB] FAIL b2b_spacing[%0d]: got %0d want 4", i, ackCyc[i] - ackCyc[i-1]); end
            vectors++; if (ackQ[i] !== 9'(i)) begin miscompares++; $display("[TB] FAIL b2b_angle[%0d]: got %0d want %0d", i, ackQ[i], i); end
        end
        abortToIdle();
    endtask

    task automatic test_consumer();
        int reqCyc;
        logic stable;
        clearLogs();
        flLatency = 2;
        ifA.hs_next_angle_i = 1'b0;
        pulseStart();
        repeat (10) tick();
        vectors++; if (ackQ.size() != 0) begin miscompares++; $display("[TB] FAIL cons_no_request_ack: got %0d acks want 0", ackQ.size()); end
        for (int k = 0; k < 3; k++) begin
            ifA.hs_next_angle_i = 1'b1;
            reqCyc = cyc;
            tick();
            ifA.hs_next_angle_i = 1'b0;
            vectors++; if (ackQ.size() != k + 1) begin
                miscompares++; $display("[TB] FAIL cons_ack_present[%0d]: got %0d acks want %0d", k, ackQ.size(), k + 1);
            end else if (ackCyc[k] != reqCyc + 1 || ackQ[k] !== 9'(k)) begin
                miscompares++; $display("[TB] FAIL cons_ack[%0d]: got cycle %0d angle %0d want cycle %0d angle %0d", k, ackCyc[k], ackQ[k], reqCyc + 1, k);
            end
            stable = 1'b1;
            for (int c = 0; c < 50; c++) begin
                tick();
                if (ifA.hs_angle_o !== 9'(k)) stable = 1'b0;
            end
            vectors++; if (stable !== 1'b1) begin miscompares++; $display("[TB] FAIL cons_hs_angle_stable[%0d]: got %0d want %0d", k, ifA.hs_angle_o, k); end
        end
        abortToIdle();
    endtask

    task automatic test_abort();
        int n;
        clearLogs();
        flLatency = 4;
        ifA.hs_next_angle_i = 1'b1;
        pulseStart();
        n = 0;
        while (flQ.size() < 11 && n < 500) begin tick(); n++; end
        tick();
        ifA.abort_i = 1'b1;
        tick();
        ifA.abort_i = 1'b0;
        vectors++; if (ifA.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %0b want 0", ifA.busy_o); end
        repeat (20) tick();
        vectors++; if (ackQ.size() != 10) begin miscompares++; $display("[TB] FAIL abort_ack_count: got %0d want 10", ackQ.size()); end
        vectors++; if (flQ.size() != 11) begin miscompares++; $display("[TB] FAIL abort_fl_count: got %0d want 11", flQ.size()); end
        vectors++; if (doneCnt != 0) begin miscompares++; $display("[TB] FAIL abort_no_done: got %0d want 0", doneCnt); end
        vectors++; if (ifA.hs_angle_o !== 9'd9) begin miscompares++; $display("[TB] FAIL abort_hs_angle_held: got %0d want 9", ifA.hs_angle_o); end
        clearLogs();
        pulseStart();
        n = 0;
        while (ackQ.size() < 1 && n < 100) begin tick(); n++; end
        vectors++; if (ackQ.size() < 1 || ackQ[0] !== 9'd0 || flQ[0] !== 9'd0) begin
            miscompares++; $display("[TB] FAIL abort_restart_angle: got %0d acks want first angle 0", ackQ.size());
        end
        abortToIdle();
    endtask

    task automatic test_conflicts();
        int n;
        logic ordered;
        clearLogs();
        flLatency = 2;
        ifA.hs_next_angle_i = 1'b1;
        ifA.start_i = 1'b1;
        ifA.abort_i = 1'b1;
        tick();
        ifA.start_i = 1'b0;
        ifA.abort_i = 1'b0;
        vectors++; if (ifA.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL conflict_abort_beats_start: got busy %0b want 0", ifA.busy_o); end
        tick();
        vectors++; if (flQ.size() != 0) begin miscompares++; $display("[TB] FAIL conflict_no_load: got %0d loads want 0", flQ.size()); end
        pulseStart();
        n = 0;
        while (doneCnt == 0 && n < 2000) begin
            ifA.start_i = (n == 50 || n == 51 || n == 300) ? 1'b1 : 1'b0;
            tick();
            n++;
        end
        ifA.start_i = 1'b0;
        repeat (3) tick();
        ordered = (ackQ.size() == 180);
        for (int i = 0; i < ackQ.size(); i++) if (ackQ[i] !== 9'(i)) ordered = 1'b0;
        vectors++; if (ordered !== 1'b1) begin miscompares++; $display("[TB] FAIL conflict_start_busy_sequence: got %0d acks want 180 in order", ackQ.size()); end
        vectors++; if (doneCnt != 1) begin miscompares++; $display("[TB] FAIL conflict_done_count: got %0d want 1", doneCnt); end
        clearLogs();
        pulseStart();
        n = 0;
        while (ackQ.size() < 3 && n < 100) begin tick(); n++; end
        rstN = 1'b0;
        #1;
        vectors++; if (ifA.hs_next_angle_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_ack_ack: got %0b want 0", ifA.hs_next_angle_ack_o); end
        vectors++; if (ifA.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_ack_busy: got %0b want 0", ifA.busy_o); end
        vectors++; if (ifA.fl_start_o !== 1'b0 || ifA.done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_ack_pulses: got fl_start %0b done %0b want 0 0", ifA.fl_start_o, ifA.done_o); end
        vectors++; if (ifA.hs_angle_o !== 9'd0) begin miscompares++; $display("[TB] FAIL rst_mid_ack_hs_angle: got %0d want 0", ifA.hs_angle_o); end
        flCntA = -1;
        rstN = 1'b1;
        tick();
    endtask

    initial begin
        rstN = 1'b0;
        ifA.start_i = 1'b0;
        ifA.abort_i = 1'b0;
        ifA.fl_done_i = 1'b0;
        ifA.hs_next_angle_i = 1'b0;
        ifB.start_i = 1'b0;
        ifB.abort_i = 1'b0;
        ifB.fl_done_i = 1'b0;
        ifB.hs_next_angle_i = 1'b1;
        test_reset();
        test_full_frame();
        test_stepped();
        test_stall();
        test_back_to_back();
        test_consumer();
        test_abort();
        test_conflicts();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
